// File: rtl/rmap_target_packet_fifo.sv
// Packet-aware FWFT FIFO between the SpaceWire receive path and the RMAP command decoder.
// Writes stay invisible to the reader until committed; an open packet can be discarded.
module rmap_target_packet_fifo #(
  parameter int DATA_WIDTH   = 9,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  wrEnable,
  input  logic                  wrCommit,
  input  logic                  wrDiscard,
  output logic                  full,
  output logic                  almostFull,
  output logic                  wrOverflow,
  output logic [DATA_WIDTH-1:0] dataOut,
  input  logic                  rdEnable,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   usedCntr,
  output logic [ADDR_WIDTH:0]   freeCntr
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_P = PTR_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      cmt_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      fill;
  logic                  wr_accept;
  logic                  rd_accept;

  // Status is derived only from registered pointers; the wrap bit disambiguates full from empty.
  always_comb begin
    fill       = wr_ptr - rd_ptr;
    full       = (fill == DEPTH_P);
    empty      = (cmt_ptr == rd_ptr);
    usedCntr   = cmt_ptr - rd_ptr;
    freeCntr   = DEPTH_P - fill;
    almostFull = (freeCntr <= AFULL_P);
    wr_accept  = wrEnable & ~full;
    rd_accept  = rdEnable & ~empty;
    dataOut    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  // A write into a slot that is discarded in the same cycle is harmless: the slot stays uncommitted.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      rd_ptr     <= '0;
      wrOverflow <= 1'b0;
    end else begin
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Discard takes priority over commit and over any write in the same cycle.
      if (wrDiscard) begin
        wr_ptr     <= cmt_ptr;
        wrOverflow <= 1'b0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (wrEnable && full) begin
          wrOverflow <= 1'b1;
        end
        if (wrCommit) begin
          cmt_ptr <= wr_ptr + PTR_W'(wr_accept);
        end
      end
    end
  end

endmodule

// File: tb/tb_rmap_target_packet_fifo.sv
// Directed vector table plus randomized packet streaming against a queue-based model.
module tb_rmap_target_packet_fifo;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          wrEnable = 1'b0;
  logic          wrCommit = 1'b0;
  logic          wrDiscard = 1'b0;
  logic          rdEnable = 1'b0;
  logic          full;
  logic          almostFull;
  logic          wrOverflow;
  logic [DW-1:0] dataOut;
  logic          empty;
  logic [AW:0]   usedCntr;
  logic [AW:0]   freeCntr;

  rmap_target_packet_fifo #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dataIn    (dataIn),
    .wrEnable  (wrEnable),
    .wrCommit  (wrCommit),
    .wrDiscard (wrDiscard),
    .full      (full),
    .almostFull(almostFull),
    .wrOverflow(wrOverflow),
    .dataOut   (dataOut),
    .rdEnable  (rdEnable),
    .empty     (empty),
    .usedCntr  (usedCntr),
    .freeCntr  (freeCntr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          empty;
    logic          full;
    logic          af;
    logic          ovf;
    logic [AW:0]   used;
    logic [AW:0]   free;
    logic          chkData;
    logic [DW-1:0] data;
  } outs_t;

  typedef struct {
    logic          wr;
    logic [DW-1:0] din;
    logic          cm;
    logic          ds;
    logic          rd;
    outs_t         ex;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // Reference model: committed words, pending (uncommitted) words, sticky overflow.
  logic [DW-1:0] cq[$];
  logic [DW-1:0] pq[$];
  logic          movf = 1'b0;

  function automatic outs_t modelOut();
    outs_t o;
    int freeN;
    freeN     = DEPTH - cq.size() - pq.size();
    o.empty   = (cq.size() == 0);
    o.full    = (freeN == 0);
    o.af      = (freeN <= AFT);
    o.ovf     = movf;
    o.used    = (AW+1)'(cq.size());
    o.free    = (AW+1)'(freeN);
    o.chkData = (cq.size() != 0);
    o.data    = (cq.size() != 0) ? cq[0] : '0;
    return o;
  endfunction

  function automatic bit modelFull();
    return (cq.size() + pq.size()) == DEPTH;
  endfunction

  task automatic modelStep(input logic wr, input logic [DW-1:0] din, input logic cm,
                           input logic ds, input logic rd);
    bit fullPre;
    fullPre = modelFull();
    if (rd && cq.size() != 0) void'(cq.pop_front());
    if (ds) begin
      pq.delete();
      movf = 1'b0;
    end else begin
      if (wr && !fullPre) pq.push_back(din);
      if (wr && fullPre) movf = 1'b1;
      if (cm) begin
        while (pq.size() != 0) cq.push_back(pq.pop_front());
      end
    end
  endtask

  function automatic outs_t mkOuts(logic e, logic f, logic a, logic o, int u, int fr,
                                   logic cd, logic [DW-1:0] d);
    outs_t x;
    x.empty = e; x.full = f; x.af = a; x.ovf = o;
    x.used = (AW+1)'(u); x.free = (AW+1)'(fr);
    x.chkData = cd; x.data = d;
    return x;
  endfunction

  function automatic void addRow(logic wr, logic [DW-1:0] din, logic cm, logic ds, logic rd,
                                 outs_t ex);
    vec_t v;
    v.wr = wr; v.din = din; v.cm = cm; v.ds = ds; v.rd = rd; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input outs_t ex);
    checks++;
    if (empty !== ex.empty || full !== ex.full || almostFull !== ex.af ||
        wrOverflow !== ex.ovf || usedCntr !== ex.used || freeCntr !== ex.free ||
        (ex.chkData && dataOut !== ex.data)) begin
      failures++;
      $display("[TB] FAIL %s: got empty=%0b full=%0b af=%0b ovf=%0b used=%0d free=%0d data=%h; expected empty=%0b full=%0b af=%0b ovf=%0b used=%0d free=%0d data=%h(chk=%0b)",
               name, empty, full, almostFull, wrOverflow, usedCntr, freeCntr, dataOut,
               ex.empty, ex.full, ex.af, ex.ovf, ex.used, ex.free, ex.data, ex.chkData);
    end
  endtask

  // Drives one cycle of inputs (called away from the edge), lets the edge happen, steps the model.
  task automatic applyStimulus(input logic wr, input logic [DW-1:0] din, input logic cm,
                               input logic ds, input logic rd);
    wrEnable = wr; dataIn = din; wrCommit = cm; wrDiscard = ds; rdEnable = rd;
    @(posedge clk);
    modelStep(wr, din, cm, ds, rd);
    #2;
  endtask

  task automatic resetPulse();
    wrEnable = 1'b0; wrCommit = 1'b0; wrDiscard = 1'b0; rdEnable = 1'b0;
    rst_n = 1'b0;
    #1;
    cq.delete(); pq.delete(); movf = 1'b0;
    checkOutput("async_reset", modelOut());
    @(posedge clk);
    #2;
    checkOutput("reset_held", modelOut());
    rst_n = 1'b1;
  endtask

  initial begin
    outs_t exReset;
    exReset = mkOuts(1, 0, 0, 0, 0, 16, 0, '0);

    // Test 2: three-word packet, hidden until committed, then popped in order.
    addRow(1, 9'h101, 0, 0, 0, mkOuts(1, 0, 0, 0, 0, 15, 0, '0));
    addRow(1, 9'h0A2, 0, 0, 0, mkOuts(1, 0, 0, 0, 0, 14, 0, '0));
    addRow(1, 9'h1FF, 1, 0, 0, mkOuts(0, 0, 0, 0, 3, 13, 1, 9'h101));
    addRow(0, 9'h000, 0, 0, 1, mkOuts(0, 0, 0, 0, 2, 14, 1, 9'h0A2));
    addRow(0, 9'h000, 0, 0, 1, mkOuts(0, 0, 0, 0, 1, 15, 1, 9'h1FF));
    addRow(0, 9'h000, 0, 0, 1, mkOuts(1, 0, 0, 0, 0, 16, 0, '0));
    // Test 3: commit two, write five, discard, next packet follows without a gap.
    addRow(1, 9'h011, 0, 0, 0, mkOuts(1, 0, 0, 0, 0, 15, 0, '0));
    addRow(1, 9'h022, 1, 0, 0, mkOuts(0, 0, 0, 0, 2, 14, 1, 9'h011));
    for (int i = 0; i < 5; i++)
      addRow(1, 9'(9'h0E0 + i), 0, 0, 0, mkOuts(0, 0, 0, 0, 2, 13 - i, 1, 9'h011));
    addRow(0, 9'h000, 0, 1, 0, mkOuts(0, 0, 0, 0, 2, 14, 1, 9'h011));
    addRow(1, 9'h033, 1, 0, 0, mkOuts(0, 0, 0, 0, 3, 13, 1, 9'h011));
    addRow(0, 9'h000, 0, 0, 1, mkOuts(0, 0, 0, 0, 2, 14, 1, 9'h022));
    addRow(0, 9'h000, 0, 0, 1, mkOuts(0, 0, 0, 0, 1, 15, 1, 9'h033));
    addRow(0, 9'h000, 0, 0, 1, mkOuts(1, 0, 0, 0, 0, 16, 0, '0));
    // Test 4: fill uncommitted, overflow, discard clears everything.
    for (int k = 1; k <= 16; k++)
      addRow(1, 9'(9'h100 + k), 0, 0, 0,
             mkOuts(1, k == 16, (16 - k) <= AFT, 0, 0, 16 - k, 0, '0));
    addRow(1, 9'h1EE, 0, 0, 0, mkOuts(1, 1, 1, 1, 0, 0, 0, '0));
    addRow(0, 9'h000, 0, 1, 0, mkOuts(1, 0, 0, 0, 0, 16, 0, '0));
    // Test 5: committed full FIFO, simultaneous read and write.
    for (int i = 0; i < 16; i++)
      addRow(1, 9'(9'h0C0 + i), i == 15, 0, 0,
             mkOuts(i != 15, i == 15, (15 - i) <= AFT, 0, (i == 15) ? 16 : 0, 15 - i,
                    i == 15, 9'h0C0));
    addRow(1, 9'h1AA, 0, 0, 1, mkOuts(0, 0, 1, 1, 15, 1, 1, 9'h0C1));
    addRow(0, 9'h000, 0, 1, 0, mkOuts(0, 0, 1, 0, 15, 1, 1, 9'h0C1));
    for (int j = 0; j < 15; j++)
      addRow(0, 9'h000, 0, 0, 1,
             mkOuts((14 - j) == 0, 0, (2 + j) <= AFT, 0, 14 - j, 2 + j, (14 - j) != 0,
                    9'(9'h0C2 + j)));

    // Test 1: reset state.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_state", exReset);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("after_release", exReset);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].cm, vecs[i].ds, vecs[i].rd);
      checkOutput($sformatf("vec%0d", i), vecs[i].ex);
    end

    // Test 6: random packet stream with one asynchronous reset mid-packet.
    begin
      int cycles = 0;
      bit rstDone = 0;
      bit timedOut = 0;
      for (int pkt = 0; pkt < 40 && !timedOut; pkt++) begin
        int len;
        int sent;
        bit doDiscard;
        len = $urandom_range(1, 7);
        sent = 0;
        doDiscard = ($urandom_range(0, 7) == 0);
        while (sent < len) begin
          logic wr, cm, ds, rd, last;
          logic [DW-1:0] din;
          bit fullPre;
          if (pkt == 20 && !rstDone && sent == len / 2) begin
            rstDone = 1;
            resetPulse();
            sent = 0;
            continue;
          end
          fullPre = modelFull();
          wr = ($urandom_range(0, 3) != 0) && (!fullPre || $urandom_range(0, 9) == 0);
          din = 9'($urandom);
          last = wr && !fullPre && (sent == len - 1);
          cm = last && !doDiscard;
          ds = last && doDiscard;
          rd = ($urandom_range(0, 1) == 1);
          applyStimulus(wr, din, cm, ds, rd);
          checkOutput($sformatf("rand_p%0d", pkt), modelOut());
          if (wr && !fullPre) sent++;
          cycles++;
          if (cycles > 20000) begin
            failures++;
            $display("[TB] FAIL rand_timeout: cycles=%0d limit=20000", cycles);
            timedOut = 1;
            break;
          end
        end
      end
      for (int n = 0; n < 64 && cq.size() != 0; n++) begin
        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("drain", modelOut());
      end
      checkOutput("final_empty", mkOuts(1, 0, 0, movf, 0, 16 - pq.size(), 0, '0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
